data_mem_responder: RTL and testbench

Responder end of the core's data-memory port. Accepts load/store requests carrying the byte address, unshifted store data and the instruction func3, and owns a word-organised RAM with registered read. Sub-word loads are performed with sign/zero extension. Sub-word stores are performed as read-modify-write. Each request completes with a one-cycle response pulse that also flags misaligned, out-of-range or illegal-func3 requests.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory request/response bundle.
// The core drives requests through the master modport; the responder uses the slave modport.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with registered read, extended sub-word loads,
// read-modify-write sub-word stores and a one-cycle response that flags rejected requests.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q;
    logic [2:0]              func3_q;
    logic [1:0]              lane_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdword_q;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             mem [0:DEPTH-1];

    logic                    accept;
    logic                    req_bad;

    // Range, func3 legality and natural alignment of an incoming request.
    function automatic logic req_illegal(input logic we, input logic [31:0] addr,
                                         input logic [2:0] f3);
        logic oor;
        logic bad_f3;
        logic misal;
        oor = |(addr >> (ADDR_WIDTH + 2));
        if (we)
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        return oor | bad_f3 | misal;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = wdata[15:0];
                else         res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign req_bad = req_illegal(bus.req_we, bus.req_addr, bus.req_func3);

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wdata_d = bus.req_wdata;
                    if (req_bad) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else if (bus.req_we && (bus.req_func3 == 3'b010)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d = WR;
                    wdata_d = store_merge(rdword_q, wdata_q, func3_q[1:0], lane_q);
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = load_extract(rdword_q, func3_q, lane_q);
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request latch and RAM port: the read address is presented while idle so the
    // word is ready in RD; a reset that pulls the state out of WR suppresses the write.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            func3_q <= bus.req_func3;
            lane_q  <= bus.req_addr[1:0];
            waddr_q <= bus.req_addr[ADDR_WIDTH+1:2];
        end
        wdata_q <= wdata_d;
        if (state_q == IDLE)
            rdword_q <= mem[bus.req_addr[ADDR_WIDTH+1:2]];
        if (state_q == WR)
            mem[waddr_q] <= wdata_q;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array memory model, directed plan steps, then random traffic.
module tb_data_mem_responder;

    localparam int AW    = 8;
    localparam int BYTES = 4 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ref_mem [0:BYTES-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3 % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        bit legal;
        if (addr >= BYTES) return 1'b1;
        if (we) legal = (f3 <= 2);
        else    legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        if (!legal) return 1'b1;
        return (addr % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        v  = 32'd0;
        for (int i = 0; i < sz; i++) v = v + (32'(ref_mem[addr + i]) << (8 * i));
        if (f3 < 4 && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
    endtask

    // One complete request; checks handshake, latency, response fields against the model.
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output logic err);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          lat;
        exp_err   = model_err(we, addr, f3);
        exp_rdata = (!exp_err && !we) ? model_load(addr, f3) : 32'd0;
        exp_lat   = exp_err ? 1 : (we && f3 != 3'b010) ? 3 : 2;
        @(negedge clk);
        chk("pulse_end", 32'(bus.rsp_valid), 32'd0);
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_func3 = f3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 1;
        chk("ready_busy", 32'(bus.req_ready), 32'd0);
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (!exp_err && we) model_store(addr, wdata, f3);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [2:0]  ld_f3 [0:4];
        int          pulses;
        int          last;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_func3 = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b1;

        for (int w = 0; w < (1 << AW); w++) do_op(1'b1, 32'(w * 4), $urandom, 3'b010, rd, er);

        do_op(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
        do_op(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("sw_lw", rd, 32'hDEADBEEF);

        do_op(1'b1, 32'h20, 32'h11223344, 3'b010, rd, er);
        do_op(1'b1, 32'h22, 32'h123456AA, 3'b000, rd, er);
        do_op(1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        chk("sb_merge", rd, 32'h11AA3344);
        do_op(1'b0, 32'h22, 32'h0, 3'b000, rd, er);
        chk("lb", rd, 32'hFFFFFFAA);
        do_op(1'b0, 32'h22, 32'h0, 3'b100, rd, er);
        chk("lbu", rd, 32'h000000AA);

        do_op(1'b1, 32'h30, 32'h0, 3'b010, rd, er);
        do_op(1'b1, 32'h32, 32'hFFFF8001, 3'b001, rd, er);
        do_op(1'b0, 32'h30, 32'h0, 3'b010, rd, er);
        chk("sh_merge", rd, 32'h80010000);
        do_op(1'b0, 32'h32, 32'h0, 3'b001, rd, er);
        chk("lh", rd, 32'hFFFF8001);
        do_op(1'b0, 32'h32, 32'h0, 3'b101, rd, er);
        chk("lhu", rd, 32'h00008001);

        do_op(1'b0, 32'h13, 32'h0, 3'b010, rd, er);
        chk("err_lw_misal", {er, rd}, {1'b1, 32'h0});
        do_op(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("after_lw_misal", rd, 32'hDEADBEEF);
        do_op(1'b1, 32'h21, 32'h5555, 3'b001, rd, er);
        chk("err_sh_misal", {er, rd}, {1'b1, 32'h0});
        do_op(1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        chk("after_sh_misal", rd, 32'h11AA3344);
        do_op(1'b0, 32'h400, 32'h0, 3'b010, rd, er);
        chk("err_range", {er, rd}, {1'b1, 32'h0});
        do_op(1'b0, 32'h10, 32'h0, 3'b011, rd, er);
        chk("err_func3", {er, rd}, {1'b1, 32'h0});
        do_op(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("after_func3", rd, 32'hDEADBEEF);

        // Reset while the SB is in WR must drop the request without writing.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h00000099;
        bus.req_func3 = 3'b000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        chk("rst_mid_nowrite", rd, 32'h11AA3344);

        // req_valid held high across back-to-back loads.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_func3 = 3'b010;
        pulses = 0;
        last   = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                pulses++;
                if (last < 0) chk("held_first", 32'(i), 32'd2);
                else          chk("held_spacing", 32'(i - last), 32'd3);
                chk("held_rdata", bus.rsp_rdata, 32'hDEADBEEF);
                last = i;
            end
        end
        bus.req_valid = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd4);

        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, (1 << AW) - 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(AW + 2, 31));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ld_f3[$urandom_range(0, 4)];
            do_op(we, addr, $urandom, f3, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
